// File: rtl/matrix_feeder.sv
// Operand frame buffer in front of matrix_mult: loads A then B from a valid/ready
// stream, pulses mm_start, replays the frame one element per cycle, then waits for mm_done.
module matrix_feeder #(
    parameter int DW = 8,
    parameter int M  = 8,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          mm_start,
    output logic [DW-1:0] mm_data,
    input  logic          mm_done,
    output logic          busy,
    output logic [7:0]    frame_cnt
);

    localparam int T  = 2 * M * N;
    localparam int CW = $clog2(T);
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        STREAM,
        WAIT
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] wr_cnt_reg;
    logic [CW-1:0] rd_cnt_reg;
    logic [CW-1:0] rd_addr;
    logic [DW-1:0] mm_data_reg;
    logic [7:0]    frame_cnt_reg;
    logic [DW-1:0] frame_mem [T];
    logic          beat;
    logic          last_wr;
    logic          last_rd;
    logic          rd_en;

    assign beat    = s_valid && (state_reg == LOAD);
    assign last_wr = (wr_cnt_reg == LAST);
    assign last_rd = (rd_cnt_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake and status outputs are pure decodes of the state register.
    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        mm_start   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (beat && last_wr) begin
                    state_next = START;
                end
            end
            START: begin
                mm_start   = 1'b1;
                busy       = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (last_rd) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (mm_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The read is issued one cycle ahead so the registered RAM output lands
    // on mm_data exactly in the cycle that presents each element.
    always_comb begin
        rd_addr = '0;
        rd_en   = 1'b0;
        case (state_reg)
            LOAD: begin
                rd_addr = '0;
                rd_en   = beat && last_wr;
            end
            START: begin
                rd_addr = CW'(1);
                rd_en   = 1'b1;
            end
            STREAM: begin
                rd_addr = rd_cnt_reg + CW'(1);
                rd_en   = !last_rd;
            end
            default: begin
                rd_addr = '0;
                rd_en   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            frame_mem[wr_cnt_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            mm_data_reg   <= '0;
            frame_cnt_reg <= '0;
        end else begin
            if (beat) begin
                wr_cnt_reg <= last_wr ? '0 : wr_cnt_reg + CW'(1);
            end

            // rd_cnt tracks the index currently shown on mm_data.
            if (state_reg == START) begin
                rd_cnt_reg <= CW'(1);
            end else if (state_reg == STREAM) begin
                rd_cnt_reg <= last_rd ? '0 : rd_cnt_reg + CW'(1);
            end

            if (rd_en) begin
                mm_data_reg <= frame_mem[rd_addr];
            end else begin
                mm_data_reg <= '0;
            end

            if ((state_reg == WAIT) && mm_done) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    assign mm_data   = mm_data_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
